// File: rtl/axil_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axil_pkg : shared types and defaults for the AXI-Lite write arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package axil_pkg;

  typedef enum logic [1:0] {
    ARB_RR    = 2'd0,
    ARB_WRR   = 2'd1,
    ARB_FIXED = 2'd2
  } arb_mode_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACKN = 1'b1
  } arb_state_t;

  localparam int c_NUM_MASTER_DEFAULT = 4;
  localparam int c_WEIGHT_W_DEFAULT   = 4;

endpackage
`default_nettype wire

// File: rtl/axil_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axil_rr_pick : combinational rotating-priority picker, search starts at start_idx
// Rev 1.0
// ---------------------------------------------------------------------------
module axil_rr_pick
  import axil_pkg::*;
#(
  parameter int N = c_NUM_MASTER_DEFAULT,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start_idx,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW:0] w_cand;

  // One extra bit keeps start_idx + k < 2N representable for non-power-of-two N.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, start_idx} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(N)) begin
        w_cand = w_cand - (IW+1)'(N);
      end
      if (!found && req[w_cand[IW-1:0]]) begin
        found                  = 1'b1;
        idx                    = w_cand[IW-1:0];
        onehot[w_cand[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axil_arbiter_wrr_wr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axil_arbiter_wrr_wr : AXI-Lite write arbiter (RR / WRR / fixed) with B watchdog
// Rev 1.0
// ---------------------------------------------------------------------------
module axil_arbiter_wrr_wr
  import axil_pkg::*;
#(
  parameter int        NUM_MASTER     = c_NUM_MASTER_DEFAULT,
  parameter arb_mode_t ARB_MODE       = ARB_WRR,
  parameter int        WEIGHT_W       = c_WEIGHT_W_DEFAULT,
  parameter int        TIMEOUT_CYCLES = 1024,
  localparam int       IW             = $clog2(NUM_MASTER)
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_MASTER-1:0]          request_wr,
  input  logic [NUM_MASTER*WEIGHT_W-1:0] weight,
  input  logic                           s_axil_bvalid,
  input  logic [NUM_MASTER-1:0]          m_axil_bready,
  output logic [NUM_MASTER-1:0]          grant_wr,
  output logic [IW-1:0]                  grant_idx,
  output logic                           grant_valid,
  output logic                           timeout_pulse,
  output logic [IW-1:0]                  timeout_idx
);

  arb_state_t          r_state;
  logic [IW-1:0]       r_last_idx;
  logic [WEIGHT_W-1:0] r_credit;

  logic [IW:0]           w_next_wide;
  logic [IW-1:0]         w_start;
  logic [NUM_MASTER-1:0] w_pick_oh;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_pick_found;
  logic                  w_hold;
  logic [NUM_MASTER-1:0] w_win_oh;
  logic [IW-1:0]         w_win_idx;
  logic                  w_win_any;
  logic [WEIGHT_W-1:0]   w_weight_sel;
  logic [WEIGHT_W-1:0]   w_credit_load;
  logic                  w_handshake;
  logic                  w_expire;

  assign w_next_wide = {1'b0, r_last_idx} + (IW+1)'(1);
  assign w_start     = (ARB_MODE == ARB_FIXED)                  ? '0 :
                       (w_next_wide >= (IW+1)'(NUM_MASTER))     ? '0 :
                                                                  w_next_wide[IW-1:0];

  axil_rr_pick #(
    .N (NUM_MASTER)
  ) u_pick (
    .req       (request_wr),
    .start_idx (w_start),
    .onehot    (w_pick_oh),
    .idx       (w_pick_idx),
    .found     (w_pick_found)
  );

  // WRR: the previous holder keeps the bus while it still has quota left.
  assign w_hold        = (ARB_MODE == ARB_WRR) && request_wr[r_last_idx] && (r_credit != '0);
  assign w_win_oh      = w_hold ? (NUM_MASTER'(1) << r_last_idx) : w_pick_oh;
  assign w_win_idx     = w_hold ? r_last_idx : w_pick_idx;
  assign w_win_any     = w_hold || w_pick_found;
  assign w_weight_sel  = weight[w_pick_idx*WEIGHT_W +: WEIGHT_W];
  assign w_credit_load = (w_weight_sel == '0) ? '0 : w_weight_sel - WEIGHT_W'(1);
  assign w_handshake   = s_axil_bvalid && m_axil_bready[grant_idx];
  assign grant_valid   = |grant_wr;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_watchdog
      localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
      logic [WD_W-1:0] r_wd_cnt;

      always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
          r_wd_cnt <= '0;
        end else if (r_state == IDLE) begin
          r_wd_cnt <= '0;
        end else begin
          r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
      end

      assign w_expire = (r_state == ACKN) && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_watchdog
      assign w_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= IDLE;
      r_last_idx    <= IW'(NUM_MASTER - 1);
      r_credit      <= '0;
      grant_wr      <= '0;
      grant_idx     <= '0;
      timeout_pulse <= 1'b0;
      timeout_idx   <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_win_any) begin
            grant_wr   <= w_win_oh;
            grant_idx  <= w_win_idx;
            r_last_idx <= w_win_idx;
            r_state    <= ACKN;
            if (ARB_MODE == ARB_WRR) begin
              // w_hold implies credit > 0, so the decrement cannot wrap.
              r_credit <= w_hold ? r_credit - WEIGHT_W'(1) : w_credit_load;
            end
          end
        end
        ACKN: begin
          if (w_handshake) begin
            grant_wr  <= '0;
            grant_idx <= '0;
            r_state   <= IDLE;
          end else if (w_expire) begin
            grant_wr      <= '0;
            grant_idx     <= '0;
            timeout_pulse <= 1'b1;
            timeout_idx   <= grant_idx;
            r_credit      <= '0;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_arbiter_wrr_wr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axil_arbiter_wrr_wr : directed bench for the RR, WRR, fixed and N=3 variants
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_axil_arbiter_wrr_wr;
  import axil_pkg::*;

  logic        clk;
  logic        areset;
  logic [3:0]  req;
  logic [3:0]  bready;
  logic        bvalid;
  logic [15:0] weight;

  logic [3:0] rr_grant, wrr_grant, fx_grant;
  logic [1:0] rr_idx, wrr_idx, fx_idx, rr_toidx, wrr_toidx, fx_toidx;
  logic       rr_gv, wrr_gv, fx_gv, rr_to, wrr_to, fx_to;
  logic [2:0] n3_grant;
  logic [1:0] n3_idx, n3_toidx;
  logic       n3_gv, n3_to;

  int n_pass;
  int n_total;

  axil_arbiter_wrr_wr #(.NUM_MASTER(4), .ARB_MODE(ARB_RR), .WEIGHT_W(4), .TIMEOUT_CYCLES(8)) u_rr (
    .aclk(clk), .areset(areset), .request_wr(req), .weight(weight),
    .s_axil_bvalid(bvalid), .m_axil_bready(bready), .grant_wr(rr_grant), .grant_idx(rr_idx),
    .grant_valid(rr_gv), .timeout_pulse(rr_to), .timeout_idx(rr_toidx));

  axil_arbiter_wrr_wr #(.NUM_MASTER(4), .ARB_MODE(ARB_WRR), .WEIGHT_W(4), .TIMEOUT_CYCLES(8)) u_wrr (
    .aclk(clk), .areset(areset), .request_wr(req), .weight(weight),
    .s_axil_bvalid(bvalid), .m_axil_bready(bready), .grant_wr(wrr_grant), .grant_idx(wrr_idx),
    .grant_valid(wrr_gv), .timeout_pulse(wrr_to), .timeout_idx(wrr_toidx));

  axil_arbiter_wrr_wr #(.NUM_MASTER(4), .ARB_MODE(ARB_FIXED), .WEIGHT_W(4), .TIMEOUT_CYCLES(0)) u_fx (
    .aclk(clk), .areset(areset), .request_wr(req), .weight(weight),
    .s_axil_bvalid(bvalid), .m_axil_bready(bready), .grant_wr(fx_grant), .grant_idx(fx_idx),
    .grant_valid(fx_gv), .timeout_pulse(fx_to), .timeout_idx(fx_toidx));

  axil_arbiter_wrr_wr #(.NUM_MASTER(3), .ARB_MODE(ARB_RR), .WEIGHT_W(4), .TIMEOUT_CYCLES(1024)) u_n3 (
    .aclk(clk), .areset(areset), .request_wr(req[2:0]), .weight(weight[11:0]),
    .s_axil_bvalid(bvalid), .m_axil_bready(bready[2:0]), .grant_wr(n3_grant), .grant_idx(n3_idx),
    .grant_valid(n3_gv), .timeout_pulse(n3_to), .timeout_idx(n3_toidx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    req    = '0;
    bvalid = 1'b0;
    bready = 4'hF;
    @(posedge clk);
    #1;
    areset = 1'b0;
  endtask

  // Holds bvalid for the second cycle of a grant, then leaves one idle cycle.
  task automatic handshake_gap();
    tick();
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    req    = 4'hF;
    bvalid = 1'b0;
    bready = 4'hF;
    weight = '0;
    #3;
    n_total++;
    if ({rr_grant, rr_idx, rr_gv, rr_to, rr_toidx} !== 10'd0)
      $display("FAIL reset_rr: outputs=%b required all zero", {rr_grant, rr_idx, rr_gv, rr_to, rr_toidx});
    else n_pass++;
    n_total++;
    if ({n3_grant, n3_idx, n3_gv, n3_to, n3_toidx} !== 9'd0)
      $display("FAIL reset_n3: outputs=%b required all zero", {n3_grant, n3_idx, n3_gv, n3_to, n3_toidx});
    else n_pass++;
    @(posedge clk);
    #1;
    areset = 1'b0;
  endtask

  task automatic test_rr();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (rr_idx !== 2'(exp_seq[i]) || rr_grant !== 4'(1 << exp_seq[i]))
        $display("FAIL rr_seq[%0d]: idx=%0d grant=%b required idx=%0d", i, rr_idx, rr_grant, exp_seq[i]);
      else n_pass++;
      handshake_gap();
      n_total++;
      if (rr_gv !== 1'b0 || rr_grant !== 4'd0)
        $display("FAIL rr_idle[%0d]: grant_valid=%b grant=%b required 0", i, rr_gv, rr_grant);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_wrr();
    int exp_seq[8] = '{0, 1, 1, 1, 2, 2, 3, 0};
    do_reset();
    weight = 16'h1231;
    req    = 4'hF;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (wrr_idx !== 2'(exp_seq[i]) || wrr_grant !== 4'(1 << exp_seq[i]))
        $display("FAIL wrr_seq[%0d]: idx=%0d grant=%b required idx=%0d", i, wrr_idx, wrr_grant, exp_seq[i]);
      else n_pass++;
      handshake_gap();
      tick();
    end
  endtask

  task automatic test_fixed();
    do_reset();
    req = 4'b1010;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (fx_idx !== 2'd1 || fx_grant !== 4'b0010)
        $display("FAIL fixed_m1[%0d]: idx=%0d grant=%b required idx=1", i, fx_idx, fx_grant);
      else n_pass++;
      if (i == 2) req = 4'b1000;
      handshake_gap();
      tick();
    end
    n_total++;
    if (fx_idx !== 2'd3 || fx_grant !== 4'b1000)
      $display("FAIL fixed_m3: idx=%0d grant=%b required idx=3", fx_idx, fx_grant);
    else n_pass++;
    for (int i = 0; i < 20; i++) tick();
    n_total++;
    if (fx_gv !== 1'b1 || fx_to !== 1'b0)
      $display("FAIL fixed_no_watchdog: grant_valid=%b timeout=%b required 1/0", fx_gv, fx_to);
    else n_pass++;
    handshake_gap();
  endtask

  task automatic test_timeout();
    do_reset();
    weight = 16'h0300;
    req    = 4'b0100;
    tick();
    n_total++;
    if (wrr_idx !== 2'd2 || wrr_grant !== 4'b0100)
      $display("FAIL to_grant: idx=%0d grant=%b required idx=2", wrr_idx, wrr_grant);
    else n_pass++;
    req = 4'hF;
    for (int i = 0; i < 7; i++) tick();
    n_total++;
    if (wrr_gv !== 1'b1 || wrr_to !== 1'b0)
      $display("FAIL to_held: grant_valid=%b timeout=%b required 1/0", wrr_gv, wrr_to);
    else n_pass++;
    tick();
    n_total++;
    if (wrr_gv !== 1'b0 || wrr_to !== 1'b1 || wrr_toidx !== 2'd2)
      $display("FAIL to_fire: grant_valid=%b timeout=%b timeout_idx=%0d required 0/1/2", wrr_gv, wrr_to, wrr_toidx);
    else n_pass++;
    tick();
    n_total++;
    if (wrr_idx !== 2'd3 || wrr_to !== 1'b0 || wrr_toidx !== 2'd2)
      $display("FAIL to_rotate: idx=%0d timeout=%b timeout_idx=%0d required 3/0/2", wrr_idx, wrr_to, wrr_toidx);
    else n_pass++;
    handshake_gap();
  endtask

  task automatic test_same_cycle();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 7; i++) tick();
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    n_total++;
    if (rr_gv !== 1'b0 || rr_to !== 1'b0 || rr_toidx !== 2'd0)
      $display("FAIL same_cycle: grant_valid=%b timeout=%b timeout_idx=%0d required 0/0/0", rr_gv, rr_to, rr_toidx);
    else n_pass++;
    req = 4'b0010;
    tick();
    req    = 4'b0000;
    bvalid = 1'b1;
    bready = 4'b1101;
    for (int i = 0; i < 3; i++) tick();
    n_total++;
    if (rr_gv !== 1'b1 || rr_idx !== 2'd1)
      $display("FAIL wrong_bready: grant_valid=%b idx=%0d required 1/1", rr_gv, rr_idx);
    else n_pass++;
    bready = 4'hF;
    tick();
    bvalid = 1'b0;
    n_total++;
    if (rr_gv !== 1'b0)
      $display("FAIL right_bready: grant_valid=%b required 0", rr_gv);
    else n_pass++;
  endtask

  task automatic test_n3();
    int exp_seq[4] = '{0, 1, 2, 0};
    do_reset();
    req = 4'b0111;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (n3_idx !== 2'(exp_seq[i]) || n3_grant !== 3'(1 << exp_seq[i]))
        $display("FAIL n3_seq[%0d]: idx=%0d grant=%b required idx=%0d", i, n3_idx, n3_grant, exp_seq[i]);
      else n_pass++;
      handshake_gap();
      tick();
    end
    n_total++;
    if (n3_idx !== 2'd1)
      $display("FAIL n3_pre_reset: idx=%0d required 1", n3_idx);
    else n_pass++;
    areset = 1'b1;
    #2;
    n_total++;
    if (n3_grant !== 3'd0 || n3_gv !== 1'b0)
      $display("FAIL n3_async_reset: grant=%b grant_valid=%b required 0", n3_grant, n3_gv);
    else n_pass++;
    #2;
    areset = 1'b0;
    tick();
    n_total++;
    if (n3_idx !== 2'd0 || n3_grant !== 3'b001)
      $display("FAIL n3_after_reset: idx=%0d grant=%b required idx=0", n3_idx, n3_grant);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    req     = '0;
    bready  = 4'hF;
    bvalid  = 1'b0;
    weight  = '0;
    areset  = 1'b0;
    test_reset();
    test_rr();
    test_wrr();
    test_fixed();
    test_timeout();
    test_same_cycle();
    test_n3();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
